// File: rtl/ex_mem_stage_reg_pkg.sv
// EX/MEM stage register shared definitions.
// Carries the shared header defines (R_SIZE, RESETABLE, MSIZE_*, DATA_SIZE),
// the MemSize encoding, the control bundle and the store-alignment helpers.
`ifndef EX_MEM_DEFINES_VH
`define EX_MEM_DEFINES_VH
`define R_SIZE    5
`define RESETABLE (1'b1)
`define MSIZE_B   2'b00
`define MSIZE_H   2'b01
`define MSIZE_W   2'b10
`define DATA_SIZE 32
`endif

package ex_mem_stage_reg_pkg;

  localparam int DATA_SIZE = `DATA_SIZE;
  localparam int R_SIZE    = `R_SIZE;

  // MemSize encoding; 2'b11 is reserved and behaves like a word access.
  typedef enum logic [1:0] {
    MSIZE_BYTE = `MSIZE_B,
    MSIZE_HALF = `MSIZE_H,
    MSIZE_WORD = `MSIZE_W,
    MSIZE_RSVD = 2'b11
  } memSize_e;

  // Per-instruction control bits travelling with the entry.
  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic memWrite;
  } ctrl_t;

  // True when the access size does not fit the low address bits.
  function automatic logic isMisaligned(input logic [1:0] memSize, input logic [1:0] addr);
    logic mis;
    case (memSize)
      `MSIZE_B: mis = 1'b0;
      `MSIZE_H: mis = addr[0];
      default:  mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte lanes touched by an aligned access of the given size.
  function automatic logic [3:0] laneMask(input logic [1:0] memSize, input logic [1:0] addr);
    logic [3:0] mask;
    case (memSize)
      `MSIZE_B: mask = 4'b0001 << addr;
      `MSIZE_H: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// EX/MEM stage bus: EX-side handshake and payload in, MEM-side entry out.
// master = surrounding pipeline (EX driver, MEM consumer), slave = stage register.
interface ex_mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              FlushM;
  logic              ValidE;
  logic              ReadyE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic [1:0]        MemSizeE;
  logic [REG_W-1:0]  WriteRegE;
  logic [DATA_W-1:0] ALUOutE;
  logic [DATA_W-1:0] WriteDataE;
  logic [DATA_W-1:0] PCE;

  logic              ValidM;
  logic              ReadyM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic [REG_W-1:0]  WriteRegM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] WriteDataM;
  logic [3:0]        ByteEnM;
  logic [DATA_W-1:0] PCM;
  logic              AdelM;
  logic              AdesM;
  logic              HazRegWriteM;

  modport master (
    output FlushM, ValidE, RegWriteE, MemtoRegE, MemWriteE, MemSizeE,
           WriteRegE, ALUOutE, WriteDataE, PCE, ReadyM,
    input  ReadyE, ValidM, RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
           ALUOutM, WriteDataM, ByteEnM, PCM, AdelM, AdesM, HazRegWriteM
  );

  modport slave (
    input  FlushM, ValidE, RegWriteE, MemtoRegE, MemWriteE, MemSizeE,
           WriteRegE, ALUOutE, WriteDataE, PCE, ReadyM,
    output ReadyE, ValidM, RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
           ALUOutM, WriteDataM, ByteEnM, PCM, AdelM, AdesM, HazRegWriteM
  );
endinterface

// File: rtl/ex_mem_store_align.sv
// Store alignment: byte strobes, lane-replicated store data and
// load/store address-error flags, computed combinationally from EX values.
module ex_mem_store_align
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        MemSize,
  input  logic [1:0]        addr,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [3:0]        ByteEn,
  output logic [DATA_W-1:0] AlignData,
  output logic              Adel,
  output logic              Ades
);

  logic misaligned_s;

  // Error flags and strobes; a misaligned or non-store access writes no lanes.
  always_comb begin
    misaligned_s = isMisaligned(MemSize, addr);
    Ades         = MemWrite & misaligned_s;
    Adel         = MemtoReg & misaligned_s;
    if (MemWrite && !misaligned_s) begin
      ByteEn = laneMask(MemSize, addr);
    end else begin
      ByteEn = 4'b0000;
    end
  end

  // Replicate the low bytes across all lanes so any strobe picks correct data.
  always_comb begin
    case (MemSize)
      `MSIZE_B: AlignData = {(DATA_W/8){WriteData[7:0]}};
      `MSIZE_H: AlignData = {(DATA_W/16){WriteData[15:0]}};
      default:  AlignData = WriteData;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready handshake.
// Optional macro EX_MEM_SKID_EN adds a one-entry skid buffer and makes
// ReadyE come straight from a flop; without it ReadyE = ~ValidM | ReadyM.
// FlushM kills every held entry; M outputs hold while MEM stalls.
module ex_mem_stage_reg
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int REG_W  = R_SIZE
) (
  input logic               clock,
  input logic               reset,
  ex_mem_stage_reg_if.slave bus
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_W-1:0]  writeReg;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] writeData;
    logic [3:0]        byteEn;
    logic [DATA_W-1:0] pc;
    logic              adel;
    logic              ades;
  } entry_t;

  localparam int               ENTRY_W  = $bits(entry_t);
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  logic              readyE_s;
  logic              inXfer_s;
  logic              outXfer_s;
  logic [3:0]        byteEnE_s;
  logic [DATA_W-1:0] alignDataE_s;
  logic              adelE_s;
  logic              adesE_s;
  entry_t            inEntry_s;

  logic              validM_r;
  entry_t            mainEntry_r;

  ex_mem_store_align #(.DATA_W(DATA_W)) u_align (
    .MemSize   (bus.MemSizeE),
    .addr      (bus.ALUOutE[1:0]),
    .MemWrite  (bus.MemWriteE),
    .MemtoReg  (bus.MemtoRegE),
    .WriteData (bus.WriteDataE),
    .ByteEn    (byteEnE_s),
    .AlignData (alignDataE_s),
    .Adel      (adelE_s),
    .Ades      (adesE_s)
  );

  // Assemble the entry captured from EX, including the alignment results.
  always_comb begin
    inEntry_s.ctrl.regWrite = bus.RegWriteE;
    inEntry_s.ctrl.memtoReg = bus.MemtoRegE;
    inEntry_s.ctrl.memWrite = bus.MemWriteE;
    inEntry_s.writeReg      = bus.WriteRegE;
    inEntry_s.aluOut        = bus.ALUOutE;
    inEntry_s.writeData     = alignDataE_s;
    inEntry_s.byteEn        = byteEnE_s;
    inEntry_s.pc            = bus.PCE;
    inEntry_s.adel          = adelE_s;
    inEntry_s.ades          = adesE_s;
  end

  assign inXfer_s  = bus.ValidE & readyE_s;
  assign outXfer_s = validM_r & bus.ReadyM;

`ifdef EX_MEM_SKID_EN
  logic   skidValid_r;
  entry_t skidEntry_r;

  // Accepting only while the skid is empty keeps ReadyE free of ReadyM.
  assign readyE_s = ~skidValid_r;

  // Main/skid sequencing: drain skid first to preserve order, park input in skid on stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validM_r    <= 1'b0;
      skidValid_r <= 1'b0;
      mainEntry_r <= {ENTRY_W{1'b0}};
      skidEntry_r <= {ENTRY_W{1'b0}};
    end else if (bus.FlushM) begin
      validM_r    <= 1'b0;
      skidValid_r <= 1'b0;
    end else if (!validM_r || bus.ReadyM) begin
      if (skidValid_r) begin
        mainEntry_r <= skidEntry_r;
        validM_r    <= 1'b1;
        skidValid_r <= 1'b0;
      end else if (inXfer_s) begin
        mainEntry_r <= inEntry_s;
        validM_r    <= 1'b1;
      end else begin
        validM_r    <= 1'b0;
      end
    end else if (inXfer_s) begin
      skidEntry_r <= inEntry_s;
      skidValid_r <= 1'b1;
    end else begin
      skidValid_r <= skidValid_r;
    end
  end
`else
  // Accept whenever the main register is empty or being consumed this cycle.
  assign readyE_s = ~validM_r | bus.ReadyM;

  // Single-register sequencing: load on input transfer, empty on drain without refill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      validM_r    <= 1'b0;
      mainEntry_r <= {ENTRY_W{1'b0}};
    end else if (bus.FlushM) begin
      validM_r    <= 1'b0;
    end else if (inXfer_s) begin
      mainEntry_r <= inEntry_s;
      validM_r    <= 1'b1;
    end else if (outXfer_s) begin
      validM_r    <= 1'b0;
    end else begin
      validM_r    <= validM_r;
    end
  end
`endif

  assign bus.ReadyE       = readyE_s;
  assign bus.ValidM       = validM_r;
  assign bus.RegWriteM    = mainEntry_r.ctrl.regWrite;
  assign bus.MemtoRegM    = mainEntry_r.ctrl.memtoReg;
  assign bus.MemWriteM    = mainEntry_r.ctrl.memWrite;
  assign bus.WriteRegM    = mainEntry_r.writeReg;
  assign bus.ALUOutM      = mainEntry_r.aluOut;
  assign bus.WriteDataM   = mainEntry_r.writeData;
  assign bus.ByteEnM      = mainEntry_r.byteEn;
  assign bus.PCM          = mainEntry_r.pc;
  assign bus.AdelM        = mainEntry_r.adel;
  assign bus.AdesM        = mainEntry_r.ades;
  // Gated by ValidM so the forwarding unit never sees a bubble or $zero write.
  assign bus.HazRegWriteM = validM_r & mainEntry_r.ctrl.regWrite & (mainEntry_r.writeReg != REG_ZERO);

endmodule
